// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: arbitration states, owner ids,
// sram-like size codes and the request payload bundle.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_I = 2'd1,
    HOLD_D = 2'd2
  } arb_state_e;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/mem_order_fifo.sv
// Order FIFO: remembers which requester owns each accepted, not yet answered
// downstream request so responses can be routed back in request order.
module mem_order_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push_i,
  input  logic pop_i,
  input  logic din_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [DEPTH-1:0] id_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign head_o  = id_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // NOTE: entry storage is not reset; pointers and count alone decide which
  // entries are valid, so a stale id is never observed.
  always_ff @(posedge clk) begin
    if (do_push) id_q[wr_ptr_q] <= din_i;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester sram-like memory port arbiter: merges fetch and execute
// requests onto one downstream port and routes in-order responses back.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        resp_err
);

  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SW-1:0] STARVE_LIMIT = SW'(STARVE_MAX);

  arb_state_e    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          resp_err_q, resp_err_d;
  logic [31:0]   inst_rdata_q, inst_rdata_d;
  logic [31:0]   data_rdata_q, data_rdata_d;

  sram_req_t inst_pl, data_pl, mem_pl;
  logic      owner, req_vld, handshake;
  logic      grant_ok, starve_hit, pop, inst_pop, data_pop;
  logic      fifo_full, fifo_empty, fifo_head;

  assign inst_pl    = {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata};
  assign data_pl    = {data_wr, data_size, data_wstrb, data_addr, data_wdata};
  assign pop        = mem_data_ok & ~fifo_empty & ~reset;
  assign grant_ok   = ~fifo_full | pop;
  assign starve_hit = inst_req & (starve_q >= STARVE_LIMIT);

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    owner   = OWNER_DATA;
    req_vld = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_ok && (inst_req || data_req)) begin
          owner   = (data_req && !starve_hit) ? OWNER_DATA : OWNER_INST;
          req_vld = 1'b1;
          if (!mem_addr_ok) state_d = (owner == OWNER_DATA) ? HOLD_D : HOLD_I;
        end
      end
      HOLD_I: begin
        owner   = OWNER_INST;
        req_vld = inst_req;
        if (mem_addr_ok || !inst_req) state_d = IDLE;
      end
      HOLD_D: begin
        owner   = OWNER_DATA;
        req_vld = data_req;
        if (mem_addr_ok || !data_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) req_vld = 1'b0;
  end

  assign handshake = req_vld & mem_addr_ok;
  assign inst_pop  = pop & (fifo_head == OWNER_INST);
  assign data_pop  = pop & (fifo_head == OWNER_DATA);

  always_comb begin
    starve_d = starve_q;
    if (!inst_req || (handshake && owner == OWNER_INST)) begin
      starve_d = '0;
    end else if (handshake && starve_q != STARVE_LIMIT) begin
      starve_d = starve_q + 1'b1;
    end
    resp_err_d   = resp_err_q | (mem_data_ok & fifo_empty);
    inst_rdata_d = inst_pop ? mem_rdata : inst_rdata_q;
    data_rdata_d = data_pop ? mem_rdata : data_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      starve_q     <= '0;
      resp_err_q   <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      resp_err_q   <= resp_err_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  mem_order_fifo #(
    .DEPTH(DEPTH)
  ) u_order_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (handshake),
    .pop_i   (pop),
    .din_i   (owner),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  // Response data bypasses the holding registers so it reaches the client in
  // the same cycle as mem_data_ok.
  assign mem_pl = req_vld ? ((owner == OWNER_DATA) ? data_pl : inst_pl) : '0;
  assign {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} = mem_pl;
  assign mem_req      = req_vld;
  assign inst_addr_ok = handshake & (owner == OWNER_INST);
  assign data_addr_ok = handshake & (owner == OWNER_DATA);
  assign inst_data_ok = inst_pop;
  assign data_data_ok = data_pop;
  assign inst_rdata   = reset ? '0 : inst_rdata_d;
  assign data_rdata   = reset ? '0 : data_rdata_d;
  assign resp_err     = resp_err_q & ~reset;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter DEPTH, default 4, is the maximum number of outstanding accepted requests; it SHALL be a power of two, 2..8.
REQ-002 Parameter STARVE_MAX, default 4, is the number of consecutive data grants allowed while inst_req is waiting.
REQ-003 The block SHALL use reset reset, synchronous, active-high; clock clk.
REQ-004 Port: clk  in  1  clock.
REQ-005 Port: reset  in  1  synchronous active-high reset.
REQ-006 Port group inst_req/inst_wr (in 1 each), inst_size (in 2), inst_wstrb (in 4), inst_addr/inst_wdata (in 32 each): sram-like request from fetch.
REQ-007 Port group inst_addr_ok/inst_data_ok (out 1 each), inst_rdata (out 32): fetch responses.
REQ-008 Port groups data_* SHALL mirror REQ-006/007 for the execute-stage data port.
REQ-009 Port group mem_req/mem_wr (out 1 each), mem_size (out 2), mem_wstrb (out 4), mem_addr/mem_wdata (out 32 each): merged downstream request.
REQ-010 Port group mem_addr_ok/mem_data_ok (in 1 each), mem_rdata (in 32): downstream responses, returned in request order.
REQ-011 Port: resp_err  out  1  sticky flag, set by mem_data_ok with no outstanding entry.

Function
REQ-012 Arbitration SHALL be in one of three states: IDLE, HOLD_I, HOLD_D.
- IDLE -> HOLD_D: data_req is high and grant is allowed.
- IDLE -> HOLD_I: only inst_req is high, or the starvation override is active.
REQ-013 In HOLD_x, mem_req and all payload SHALL come from requester x only, and x_addr_ok SHALL equal mem_addr_ok; the non-owner's addr_ok SHALL be 0.
REQ-014 A HOLD_x state SHALL return to IDLE in the cycle after mem_addr_ok; it SHALL NOT switch owner before then.
REQ-015 IDLE SHALL drive the winning request combinationally in the same cycle, so that zero-wait acceptance is possible.
REQ-016 Priority SHALL be data over inst, except when the starvation counter reaches STARVE_MAX while inst_req is pending; then inst wins once.
- The counter SHALL clear on any inst grant.
- The counter SHALL clear whenever inst_req is low.
REQ-017 Grant SHALL be allowed only when the FIFO is not full, or when mem_data_ok pops in the same cycle.
- When grant is not allowed, mem_req SHALL be 0 and the state SHALL remain IDLE.
REQ-018 Each mem_req&mem_addr_ok handshake SHALL push the owner id (0=inst, 1=data) into the order FIFO.
REQ-019 Each mem_data_ok SHALL pop the FIFO head.
- mem_rdata SHALL route to the head owner, and that owner's data_ok SHALL pulse in the same cycle.
- The other owner's data_ok SHALL be 0, and its rdata SHALL hold its last value.
REQ-020 A simultaneous push and pop SHALL leave the count unchanged. Pointers SHALL wrap modulo DEPTH.
REQ-021 mem_data_ok with an empty FIFO SHALL set resp_err and drop the response; no client data_ok SHALL pulse.
REQ-022 Added latency SHALL be 0 cycles on both the request and response paths.

Reset
REQ-023 Reset SHALL set: state=IDLE, FIFO empty, starvation counter=0, resp_err=0, rdata registers=0.
REQ-024 While reset is high, all outputs SHALL be 0.
REQ-025 Responses arriving after a reset applied mid-transaction SHALL be handled per REQ-021.

Structure
REQ-026 A shared package SHALL hold: the state enum (IDLE/HOLD_I/HOLD_D), the owner-id constants, and the sram-like size encodings (byte 2'b00, half 2'b01, word 2'b10).
REQ-027 The order FIFO SHALL be a sub-module named mem_order_fifo (1-bit wide, DEPTH entries, push/pop/full/empty/head).

Verification
REQ-028 Scenario: inst_req and data_req both high, mem_addr_ok=1 every cycle.
- Required: data granted; inst granted the next cycle after data_req drops; FIFO ids {1,0}.
REQ-029 Scenario: data_req held high for 6 cycles with inst_req high and mem_addr_ok=1.
- Required: inst granted on the 5th handshake (STARVE_MAX=4), data thereafter.
REQ-030 Scenario: 4 accepted reads, no mem_data_ok.
- Required: mem_req=0 while full; a 5th request is accepted in the cycle mem_data_ok pops.
REQ-031 Scenario: ordered reads inst@0x1c000000, then data@0x100.
- Required: mem_rdata 0xAAAA5555 goes to inst_rdata with inst_data_ok; 0x12345678 goes to data_rdata with data_data_ok.
REQ-032 Scenario: mem_addr_ok held low for 3 cycles while data is owner and inst_req rises.
- Required: mem_addr stays at the data address until acceptance.
REQ-033 Scenario: mem_data_ok with FIFO empty; then reset with 2 outstanding, followed by 2 data_ok.
- Required: resp_err=1 after the first event, and no client data_ok at any point.
